// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the WM8978 I2S master path.
package i2s_pkg;

    localparam int WL_16 = 16;
    localparam int WL_24 = 24;
    localparam int WL_32 = 32;

    localparam logic LRC_LEFT  = 1'b0;
    localparam logic LRC_RIGHT = 1'b1;

    function automatic int frame_w(input int wl);
        return 2 * wl;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider with rise/fall strobes, frame-position counter and word select.
// With I2S_RX_EN defined a rise strobe is exported for the receive sampler.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int WL      = 32,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk_o,
    output logic lrc_o,
`ifdef I2S_RX_EN
    output logic rise_o,
`endif
    output logic fall_o,
    output logic last_o
);

    localparam int FW = frame_w(WL);
    localparam int PW = $clog2(FW);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(FW - 1);
    localparam logic [PW-1:0] LRC_LO   = PW'(WL - 1);
    localparam logic [PW-1:0] LRC_HI   = PW'(FW - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic [PW-1:0] p_q, p_d;
    logic          lrc_q, lrc_d;
    logic          tick;

    assign tick   = (cnt_q == CNT_LAST);
    assign fall_o = tick & bclk_q;
    assign last_o = (p_q == P_LAST);
    assign bclk_o = bclk_q;
    assign lrc_o  = lrc_q;
`ifdef I2S_RX_EN
    assign rise_o = tick & ~bclk_q;
`endif

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        bclk_d = tick ? ~bclk_q : bclk_q;
        p_d    = p_q;
        lrc_d  = lrc_q;
        if (fall_o) begin
            p_d   = last_o ? '0 : p_q + PW'(1);
            // Word select leads each slot MSB by one bit clock.
            lrc_d = (p_d >= LRC_LO && p_d <= LRC_HI) ? LRC_RIGHT : LRC_LEFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
            p_q    <= P_LAST;
            lrc_q  <= LRC_LEFT;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
            p_q    <= p_d;
            lrc_q  <= lrc_d;
        end
    end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S clock-master transmitter: one-frame buffer, MSB-first shifter, valid/ready input.
// Define I2S_RX_EN to add the receive path (aud_adcdat -> rx_data / rx_valid).
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int WL      = 32,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*WL-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            aud_bclk,
    output logic            aud_lrc,
    output logic            aud_dacdat,
    output logic            frame_start,
    output logic            underrun
`ifdef I2S_RX_EN
    ,
    input  logic            aud_adcdat,
    output logic [2*WL-1:0] rx_data,
    output logic            rx_valid
`endif
);

    localparam int FW = frame_w(WL);

    logic          fall, last, load, shift, accept;
    logic          full_q, full_d;
    logic [FW-1:0] buf_q, buf_d;
    logic [FW-1:0] sh_q, sh_d;
    logic          ready_q, ready_d;
    logic          fs_q, fs_d;
    logic          ur_q, ur_d;
`ifdef I2S_RX_EN
    logic          rise;
`endif

    i2s_clk_gen #(
        .WL      (WL),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .bclk_o (aud_bclk),
        .lrc_o  (aud_lrc),
`ifdef I2S_RX_EN
        .rise_o (rise),
`endif
        .fall_o (fall),
        .last_o (last)
    );

    // The fall that wraps the position counter to 0 starts a new frame.
    assign load   = fall & last;
    assign shift  = fall & ~last;
    assign accept = tx_valid & ready_q;

    always_comb begin
        full_d = full_q;
        buf_d  = buf_q;
        sh_d   = sh_q;
        fs_d   = 1'b0;
        ur_d   = 1'b0;
        if (load) begin
            sh_d   = full_q ? buf_q : '0;
            full_d = 1'b0;
            fs_d   = 1'b1;
            ur_d   = ~full_q;
        end else if (shift) begin
            sh_d = {sh_q[FW-2:0], 1'b0};
        end
        // An accept coinciding with an empty-buffer frame start refills for the next frame.
        if (accept) begin
            buf_d  = tx_data;
            full_d = 1'b1;
        end
        ready_d = ~full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            buf_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            full_q  <= full_d;
            buf_q   <= buf_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign tx_ready    = ready_q;
    assign aud_dacdat  = sh_q[FW-1];
    assign frame_start = fs_q;
    assign underrun    = ur_q;

`ifdef I2S_RX_EN
    logic [FW-1:0] rsh_q, rsh_d;
    logic [FW-1:0] rxd_q, rxd_d;
    logic          armed_q, armed_d;
    logic          rxv_q, rxv_d;

    // Nothing is published until a full frame has been sampled from its first p=0.
    always_comb begin
        rsh_d   = rsh_q;
        rxd_d   = rxd_q;
        armed_d = armed_q | load;
        rxv_d   = 1'b0;
        if (rise) begin
            rsh_d = {rsh_q[FW-2:0], aud_adcdat};
            if (last && armed_q) begin
                rxd_d = rsh_d;
                rxv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsh_q   <= '0;
            rxd_q   <= '0;
            armed_q <= 1'b0;
            rxv_q   <= 1'b0;
        end else begin
            rsh_q   <= rsh_d;
            rxd_q   <= rxd_d;
            armed_q <= armed_d;
            rxv_q   <= rxv_d;
        end
    end

    assign rx_data  = rxd_q;
    assign rx_valid = rxv_q;
`endif

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed self-checking bench for i2s_master_tx at WL=32, CLK_DIV=4.
module tb_i2s_master_tx;

    localparam int WL        = 32;
    localparam int CLK_DIV   = 4;
    localparam int FW        = 2 * WL;
    localparam int FRAME_CYC = 2 * FW * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          aud_bclk;
    logic          aud_lrc;
    logic          aud_dacdat;
    logic          frame_start;
    logic          underrun;
`ifdef I2S_RX_EN
    logic          aud_adcdat;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    assign aud_adcdat = aud_dacdat;
`endif

    i2s_master_tx #(
        .WL      (WL),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .aud_bclk    (aud_bclk),
        .aud_lrc     (aud_lrc),
        .aud_dacdat  (aud_dacdat),
        .frame_start (frame_start),
        .underrun    (underrun)
`ifdef I2S_RX_EN
        ,
        .aud_adcdat  (aud_adcdat),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          stream_en = 1'b0;
    bit          rdy_chk = 1'b0;
    bit          mfull = 1'b0;
    int          rdy_viol = 0;
    logic [31:0] k_next = 32'd0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set at a negedge are taken by the following posedge.
    task automatic step();
        bit pre;
        pre = (tx_valid === 1'b1) && (tx_ready === 1'b1);
        @(negedge clk);
        if (frame_start === 1'b1) mfull = 1'b0;
        if (pre) begin
            mfull = 1'b1;
            if (stream_en) begin
                k_next  = k_next + 32'd1;
                tx_data = {~k_next, k_next};
            end
        end
        if (rdy_chk && (tx_ready !== !mfull)) rdy_viol++;
    endtask

    task automatic wait_bclk(input logic lvl, output int n, output bit ok);
        logic prev;
        prev = aud_bclk;
        n    = 0;
        ok   = 1'b0;
        while (n < 4 * CLK_DIV && !ok) begin
            step();
            n++;
            if (prev !== lvl && aud_bclk === lvl) ok = 1'b1;
            prev = aud_bclk;
        end
    endtask

    task automatic wait_fs(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < FRAME_CYC + 16 && !ok) begin
            step();
            n++;
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic capture(output logic [FW-1:0] d, output logic [FW-1:0] l, output int bad);
        int n;
        bit ok;
        d   = '0;
        l   = '0;
        bad = 0;
        for (int i = 0; i < FW; i++) begin
            wait_bclk(1'b1, n, ok);
            if (!ok || (i > 0 && n != 2 * CLK_DIV)) bad++;
            d = {d[FW-2:0], aud_dacdat};
            l = {l[FW-2:0], aud_lrc};
        end
    endtask

`ifdef I2S_RX_EN
    task automatic wait_rx(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < FRAME_CYC + 16 && !ok) begin
            step();
            n++;
            if (rx_valid === 1'b1) ok = 1'b1;
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] d;
        logic [FW-1:0] l;
        int            bad;
        int            n;
        int            ur_seen;
        int            miss;
        bit            ok;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {58'd0, aud_bclk, aud_lrc, aud_dacdat, tx_ready, frame_start, underrun}, '0);
`ifdef I2S_RX_EN
        chk("reset_rx", {rx_data[FW-2:0], rx_valid}, '0);
`endif

        rst = 1'b0;
        step();
        chk("ready_after_reset", 64'(tx_ready), 64'd1);
        wait_fs(n, ok);
        chk("first_fs_latency", 64'(n), 64'd7);
        chk("first_underrun", 64'(underrun), 64'd1);
        capture(d, l, bad);
        chk("frame0_silent", d, '0);
        chk("frame0_bclk_period", 64'(bad), 64'd0);

        tx_valid = 1'b1;
        tx_data  = {32'hA5A5_0001, 32'h8000_0000};
        step();
        tx_valid = 1'b0;
        chk("ready_low_after_accept", 64'(tx_ready), 64'd0);
        wait_fs(n, ok);
        chk("frame1_fs_found", 64'(ok), 64'd1);
        chk("frame1_no_underrun", 64'(underrun), 64'd0);
        chk("ready_after_consume", 64'(tx_ready), 64'd1);
        capture(d, l, bad);
        chk("frame1_data", d, {32'hA5A5_0001, 32'h8000_0000});
        chk("frame1_lrc", l, 64'h0000_0001_FFFF_FFFE);
        chk("frame1_bclk_period", 64'(bad), 64'd0);

        stream_en = 1'b1;
        rdy_chk   = 1'b1;
        mfull     = 1'b0;
        k_next    = 32'd0;
        ur_seen   = 0;
        tx_valid  = 1'b1;
        tx_data   = {~32'd0, 32'd0};
        for (int f = 0; f < 10; f++) begin
            wait_fs(n, ok);
            if (!ok || underrun !== 1'b0) ur_seen++;
            capture(d, l, bad);
            chk($sformatf("stream_frame%0d", f), d, {~32'(f), 32'(f)});
        end
        chk("stream_no_underrun", 64'(ur_seen), 64'd0);
        chk("stream_ready_window", 64'(rdy_viol), 64'd0);
        stream_en = 1'b0;
        rdy_chk   = 1'b0;
        tx_valid  = 1'b0;

        wait_fs(n, ok);
        chk("k10_no_underrun", 64'(underrun), 64'd0);
        tx_valid = 1'b1;
        tx_data  = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        step();
        tx_valid = 1'b0;
        chk("buffer_full_before_reset", 64'(tx_ready), 64'd0);
        miss = 0;
        for (int i = 0; i < 20; i++) begin
            wait_bclk(1'b0, n, ok);
            if (!ok) miss++;
        end
        chk("p20_reached", 64'(miss), 64'd0);
        chk("dacdat_at_p20", 64'(aud_dacdat), 64'd1);
        rst = 1'b1;
        step();
        chk("midreset_outputs", {58'd0, aud_bclk, aud_lrc, aud_dacdat, tx_ready, frame_start, underrun}, '0);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("ready_after_midreset", 64'(tx_ready), 64'd1);

        repeat (6) step();
        tx_valid = 1'b1;
        tx_data  = {32'h1357_9BDF, 32'h2468_ACE0};
        step();
        tx_valid = 1'b0;
        chk("collision_fs", 64'(frame_start), 64'd1);
        chk("collision_underrun", 64'(underrun), 64'd1);
        chk("collision_buffered", 64'(tx_ready), 64'd0);
        capture(d, l, bad);
        chk("collision_silent", d, '0);
        wait_fs(n, ok);
        chk("collision_next_no_underrun", {62'd0, ok, underrun}, 64'd2);
        capture(d, l, bad);
        chk("collision_data", d, {32'h1357_9BDF, 32'h2468_ACE0});

`ifdef I2S_RX_EN
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_fs(n, ok);
        tx_valid = 1'b1;
        tx_data  = {32'h1234_5678, 32'h9ABC_DEF0};
        step();
        tx_valid = 1'b0;
        wait_rx(ok);
        chk("rx_first_found", 64'(ok), 64'd1);
        chk("rx_first_zero", rx_data, '0);
        step();
        chk("rx_valid_one_clk", 64'(rx_valid), 64'd0);
        wait_rx(ok);
        chk("rx_second_found", 64'(ok), 64'd1);
        chk("rx_frame", rx_data, {32'h1234_5678, 32'h9ABC_DEF0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
